mesi_snoop_responder: RTL
=========================

Name: mesi_snoop_responder

Overview:
- Snoop-side responder for one core's cache in the two-core MESI system.
- Takes bus snoop requests (BusRd, BusRdX, BusUpgr) from the coherency controller and looks up that core's tag/state array.
- Flushes a Modified line as a 4-word burst, writes the new MESI state, then returns a hit/shared/dirty response.
- One instance per core, placed between the core's cache array and the controller's snoop bus.

Parameters:
- CACHE_LINES, 64, lines per core cache; index width is log2(CACHE_LINES) = 6.
- WORDS_PER_LINE, 4, 32-bit words per line; fixed at 4 for this revision.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- snp_valid  in  1  snoop request valid.
- snp_ready  out  1  responder can accept; high only in IDLE.
- snp_addr  in  32  snooped byte address; tag [31:10], index [9:4], offset [3:2].
- snp_op  in  2  00 BusRd, 01 BusRdX, 10 BusUpgr, 11 reserved.
- arr_rd_en  out  1  array read strobe; read data valid the next cycle.
- arr_index  out  6  line index for reads and state writes.
- arr_word_sel  out  2  word select for data reads.
- arr_tag  in  22  tag of the line read.
- arr_state  in  2  MESI state of the line read; M=00, E=01, S=10, I=11.
- arr_word  in  32  selected data word.
- arr_st_we  out  1  one-cycle state write strobe.
- arr_st_value  out  2  new MESI state.
- flush_valid  out  1  flush word valid.
- flush_ready  in  1  flush word accepted.
- flush_data  out  32  flush word.
- flush_last  out  1  marks word 3 of the flush.
- resp_valid  out  1  snoop response valid.
- resp_ready  in  1  response accepted.
- resp_hit  out  1  line present (state != I and tag match).
- resp_shared  out  1  line retained in S after the snoop.
- resp_dirty  out  1  line was M and has been flushed.
- resp_err  out  1  reserved op, or BusUpgr hitting M/E.
- busy  out  1  state != IDLE.

Behaviour:
- Reset, asynchronous: FSM goes to IDLE. All registered outputs, word counter and flush buffer clear to 0; snp_ready is 1 after reset release.
- Reset mid-operation aborts the snoop: no state write, flush dropped, no response.
- States: IDLE, LOOKUP, CHECK, FETCH, FLUSH, UPDATE, RESP.
- IDLE:
  - snp_valid && snp_ready latches addr and op; next state LOOKUP.
- LOOKUP:
  - arr_rd_en=1, arr_index=addr[9:4], arr_word_sel=0.
  - Next state CHECK.
- CHECK: samples arr_tag/arr_state; hit = (arr_state != I) && (arr_tag == addr[31:10]).
  - Miss, op 00/01/10: no write, all resp flags 0 -> RESP.
  - Op 11, any lookup result: resp_err=1, no write -> RESP.
  - BusRd: M -> FETCH, new S, dirty=1, shared=1. E -> new S, shared=1. S -> no write, shared=1.
  - BusRdX: M -> FETCH, new I, dirty=1. E or S -> new I.
  - BusUpgr: S -> new I. M or E -> resp_err=1, no write. Hit is still reported.
  - A state change goes to UPDATE; no change goes to RESP.
- FETCH: 5 cycles.
  - Cycles 0-3: arr_rd_en=1, arr_word_sel=0..3.
  - Each word is captured into the 4-word buffer the following cycle.
  - Then go to FLUSH.
- FLUSH:
  - flush_valid=1, flush_data=buf[cnt], flush_last=(cnt==3).
  - cnt advances only on flush_ready; data is held stable while stalled.
  - After word 3 is accepted -> UPDATE. cnt wraps to 0.
- UPDATE:
  - arr_st_we=1 for exactly one cycle, arr_index latched, arr_st_value=new state.
  - Next state RESP. The state write always precedes the response.
- RESP:
  - resp_valid=1; flags are held stable until resp_ready.
  - On handshake: clear resp_valid and flags -> IDLE. snp_ready returns the cycle after.
- Latency, no stalls, accept at cycle T:
  - Miss or no-change: resp_valid at T+3.
  - E/S with state change: resp_valid at T+4.
  - M: first flush_valid at T+8, arr_st_we one cycle after the word-3 handshake, resp_valid the cycle after that.
- Only one snoop is in flight; snp_valid outside IDLE is ignored (ready=0).
- resp_ready or flush_ready asserted outside RESP/FLUSH has no effect.

Test Plan:
- Reset, then BusRd to 0x0000_0410 with line 1 tag 0x00001 in E -> arr_st_we with value 10 at T+3; resp hit=1 shared=1 dirty=0 at T+4.
- BusRdX to 0x0000_0410 with line 1 in M, words 0xA0..0xA3, flush_ready low 3 cycles on word 1 -> flush 0xA0,0xA1,0xA2,0xA3 in order, data held during the stall, last on 0xA3; st write 11; resp hit=1 dirty=1 shared=0.
- BusRd with tag mismatch (arr_tag 0x00002) -> no arr_st_we, no flush; resp hit=0 at T+3.
- BusUpgr hitting E, and op 11 -> resp_err=1, no state write.
- Second snp_valid held during a flush -> snp_ready=0 until one cycle after the resp handshake; the second snoop is then accepted.
- Assert reset during FLUSH word 2 -> flush_valid/resp_valid drop immediately, no arr_st_we; a next snoop completes normally.

Source files
------------

// File: rtl/mesi_snoop_responder.sv
// Snoop-side MESI responder for one core: looks up the snooped line, flushes a
// Modified line as a word burst, writes the new state, then answers the snoop.
module mesi_snoop_responder #(
    parameter int CACHE_LINES    = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                snp_valid_i,
    output logic                                snp_ready_o,
    input  logic [31:0]                         snp_addr_i,
    input  logic [1:0]                          snp_op_i,
    output logic                                arr_rd_en_o,
    output logic [$clog2(CACHE_LINES)-1:0]      arr_index_o,
    output logic [1:0]                          arr_word_sel_o,
    input  logic [27-$clog2(CACHE_LINES):0]     arr_tag_i,
    input  logic [1:0]                          arr_state_i,
    input  logic [31:0]                         arr_word_i,
    output logic                                arr_st_we_o,
    output logic [1:0]                          arr_st_value_o,
    output logic                                flush_valid_o,
    input  logic                                flush_ready_i,
    output logic [31:0]                         flush_data_o,
    output logic                                flush_last_o,
    output logic                                resp_valid_o,
    input  logic                                resp_ready_i,
    output logic                                resp_hit_o,
    output logic                                resp_shared_o,
    output logic                                resp_dirty_o,
    output logic                                resp_err_o,
    output logic                                busy_o
);
    localparam int IDX_W = $clog2(CACHE_LINES);
    localparam int TAG_W = 28 - IDX_W;
    localparam int CNT_W = $clog2(WORDS_PER_LINE + 1);
    localparam int WSEL_W = $clog2(WORDS_PER_LINE);
    localparam logic [CNT_W-1:0] FETCH_END = CNT_W'(WORDS_PER_LINE);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_LINE - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_FETCH  = 3'd3;
    localparam logic [2:0] S_FLUSH  = 3'd4;
    localparam logic [2:0] S_UPDATE = 3'd5;
    localparam logic [2:0] S_RESP   = 3'd6;

    localparam logic [1:0] MESI_M = 2'b00;
    localparam logic [1:0] MESI_S = 2'b10;
    localparam logic [1:0] MESI_I = 2'b11;

    localparam logic [1:0] OP_RD   = 2'b00;
    localparam logic [1:0] OP_RDX  = 2'b01;
    localparam logic [1:0] OP_RSVD = 2'b11;

    logic [2:0]        state_q, state_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [1:0]        op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        new_st_q, new_st_d;
    logic              hit_q, hit_d;
    logic              shared_q, shared_d;
    logic              dirty_q, dirty_d;
    logic              err_q, err_d;
    logic [31:0]       line_buf_q [WORDS_PER_LINE];
    logic [WORDS_PER_LINE-1:0] buf_we;
    logic              lookup_hit;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^snp_addr_i[3:0];
    assign lookup_hit = (arr_state_i != MESI_I) && (arr_tag_i == tag_q);

    always_comb begin
        state_d  = state_q;
        tag_d    = tag_q;
        idx_d    = idx_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        new_st_d = new_st_q;
        hit_d    = hit_q;
        shared_d = shared_q;
        dirty_d  = dirty_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (snp_valid_i) begin
                    tag_d   = snp_addr_i[31:4+IDX_W];
                    idx_d   = snp_addr_i[4 +: IDX_W];
                    op_d    = snp_op_i;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: state_d = S_CHECK;
            S_CHECK: begin
                hit_d    = lookup_hit;
                shared_d = 1'b0;
                dirty_d  = 1'b0;
                err_d    = 1'b0;
                new_st_d = arr_state_i;
                cnt_d    = '0;
                if (op_q == OP_RSVD) begin
                    err_d = 1'b1;
                end else if (lookup_hit) begin
                    case (op_q)
                        OP_RD: begin
                            new_st_d = MESI_S;
                            shared_d = 1'b1;
                            dirty_d  = (arr_state_i == MESI_M);
                        end
                        OP_RDX: begin
                            new_st_d = MESI_I;
                            dirty_d  = (arr_state_i == MESI_M);
                        end
                        default: begin
                            // BusUpgr is only legal against a Shared copy
                            if (arr_state_i == MESI_S) new_st_d = MESI_I;
                            else                       err_d    = 1'b1;
                        end
                    endcase
                end
                if (dirty_d)                       state_d = S_FETCH;
                else if (new_st_d != arr_state_i)  state_d = S_UPDATE;
                else                               state_d = S_RESP;
            end
            S_FETCH: begin
                // Reads issue on counts 0..N-1; each word lands one count later
                if (cnt_q == FETCH_END) begin
                    cnt_d   = '0;
                    state_d = S_FLUSH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FLUSH: begin
                if (flush_ready_i) begin
                    if (cnt_q == LAST_WORD) begin
                        cnt_d   = '0;
                        state_d = S_UPDATE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_UPDATE: state_d = S_RESP;
            S_RESP: begin
                if (resp_ready_i) begin
                    hit_d    = 1'b0;
                    shared_d = 1'b0;
                    dirty_d  = 1'b0;
                    err_d    = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            tag_q    <= '0;
            idx_q    <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            new_st_q <= '0;
            hit_q    <= 1'b0;
            shared_q <= 1'b0;
            dirty_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tag_q    <= tag_d;
            idx_q    <= idx_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            new_st_q <= new_st_d;
            hit_q    <= hit_d;
            shared_q <= shared_d;
            dirty_q  <= dirty_d;
            err_q    <= err_d;
        end
    end

    for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_line_buf
        assign buf_we[gi] = (state_q == S_FETCH) && (cnt_q == CNT_W'(gi + 1));

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i)         line_buf_q[gi] <= '0;
            else if (buf_we[gi]) line_buf_q[gi] <= arr_word_i;
        end
    end

    assign snp_ready_o    = (state_q == S_IDLE);
    assign busy_o         = (state_q != S_IDLE);
    assign arr_rd_en_o    = (state_q == S_LOOKUP) ||
                            ((state_q == S_FETCH) && (cnt_q != FETCH_END));
    assign arr_index_o    = idx_q;
    assign arr_word_sel_o = (state_q == S_FETCH) ? cnt_q[1:0] : 2'b00;
    assign arr_st_we_o    = (state_q == S_UPDATE);
    assign arr_st_value_o = new_st_q;
    assign flush_valid_o  = (state_q == S_FLUSH);
    assign flush_data_o   = line_buf_q[cnt_q[WSEL_W-1:0]];
    assign flush_last_o   = (state_q == S_FLUSH) && (cnt_q == LAST_WORD);
    assign resp_valid_o   = (state_q == S_RESP);
    assign resp_hit_o     = (state_q == S_RESP) && hit_q;
    assign resp_shared_o  = (state_q == S_RESP) && shared_q;
    assign resp_dirty_o   = (state_q == S_RESP) && dirty_q;
    assign resp_err_o     = (state_q == S_RESP) && err_q;

endmodule
